// File: rtl/pnarray_conf_seq_if.sv
// Wishbone slave bus between the user-project wrapper and the pnarray configuration sequencer.
// Signal names keep the Caravel wbs_* spelling so the wrapper wiring reads one-to-one.
interface pnarray_conf_seq_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/pnarray_conf_seq.sv
// Wishbone-driven sequencer that drives pnarray's configuration pins with glitch-free
// setup / strobe / hold sequences, fed by a small config-word FIFO.
module pnarray_conf_seq #(
  parameter int SETUP = 2,
  parameter int PULSE = 2,
  parameter int DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  pnarray_conf_seq_if.slave wb,
  output logic        arr_enable,
  output logic [7:0]  arr_raddr,
  output logic [7:0]  arr_caddr,
  output logic        arr_reset,
  output logic        arr_confclk,
  output logic        arr_rconfclk,
  output logic [31:0] arr_data_in,
  input  logic [31:0] arr_data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_SET, S_STRB, S_HOLD, S_NEXT} state_t;
  typedef enum logic [1:0] {OP_SAMPLE, OP_RESET, OP_CONF, OP_RCONF} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [7:0]    tmr_q, tmr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, cmderr_q, cmderr_d;
  logic [31:0]   sample_q, sample_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_o_q, dat_o_d;
  logic          arr_enable_q, arr_enable_d;
  logic [7:0]    arr_raddr_q, arr_raddr_d, arr_caddr_q, arr_caddr_d;
  logic          arr_reset_q, arr_reset_d, arr_confclk_q, arr_confclk_d;
  logic          arr_rconfclk_q, arr_rconfclk_d;
  logic [31:0]   arr_data_in_q, arr_data_in_d;

  logic [31:0]   fifo_mem [DEPTH];
  logic          valid, wr, rd, push, pop, full, empty, word_op;
  logic [1:0]    sel;
  op_t           cmd_op;
  logic [31:0]   head, status;

  logic unused_bits;
  assign unused_bits = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0],
                         wb.wbs_dat_i[31:24], wb.wbs_dat_i[7:2]};

  always_comb begin
    valid   = wb.wbs_cyc_i & wb.wbs_stb_i;
    ack_d   = valid & ~ack_q;
    wr      = ack_d & wb.wbs_we_i;
    rd      = ack_d & ~wb.wbs_we_i;
    sel     = wb.wbs_adr_i[3:2];
    cmd_op  = op_t'(wb.wbs_dat_i[1:0]);
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    word_op = (op_q == OP_CONF) || (op_q == OP_RCONF);
    head    = fifo_mem[rd_ptr_q];
    status  = {20'h0, 4'(count_q), 3'b000, cmderr_q, ovf_q, empty, full, state_q != S_IDLE};

    state_d        = state_q;
    op_d           = op_q;
    tmr_d          = tmr_q;
    ovf_d          = ovf_q;
    cmderr_d       = cmderr_q;
    sample_d       = sample_q;
    arr_raddr_d    = arr_raddr_q;
    arr_caddr_d    = arr_caddr_q;
    arr_data_in_d  = arr_data_in_q;
    pop            = 1'b0;

    push = wr && (sel == 2'd1) && !full;
    if (wr && (sel == 2'd2)) begin
      ovf_d    = 1'b0;
      cmderr_d = 1'b0;
    end
    if (wr && (sel == 2'd1) && full) ovf_d = 1'b1;
    if (wr && (sel == 2'd0) && (state_q != S_IDLE)) cmderr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // Word-consuming ops with nothing queued are acknowledged but leave the pins alone.
        if (wr && (sel == 2'd0) &&
            !(((cmd_op == OP_CONF) || (cmd_op == OP_RCONF)) && empty)) begin
          op_d        = cmd_op;
          arr_raddr_d = wb.wbs_dat_i[15:8];
          arr_caddr_d = wb.wbs_dat_i[23:16];
          tmr_d       = '0;
          state_d     = S_SET;
        end
      end
      S_SET: begin
        if (tmr_q == 8'(SETUP - 1)) begin
          tmr_d   = '0;
          state_d = (op_q == OP_SAMPLE) ? S_HOLD : S_STRB;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_STRB: begin
        if (tmr_q == 8'(PULSE - 1)) begin
          tmr_d   = '0;
          state_d = S_HOLD;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (tmr_q == 8'(SETUP - 1)) begin
          tmr_d   = '0;
          state_d = S_NEXT;
          if (op_q == OP_SAMPLE) sample_d = arr_data_out;
          pop = word_op && !empty;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_NEXT: begin
        tmr_d   = '0;
        state_d = ((op_q == OP_CONF) && !empty) ? S_SET : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Pins follow the state one cycle later, so enable drops only after the strobe is already low.
    arr_enable_d   = (state_q == S_SET) || (state_q == S_STRB) || (state_q == S_HOLD);
    arr_reset_d    = (state_q == S_STRB) && (op_q == OP_RESET);
    arr_confclk_d  = (state_q == S_STRB) && (op_q == OP_CONF);
    arr_rconfclk_d = (state_q == S_STRB) && (op_q == OP_RCONF);
    if ((state_q == S_SET) && word_op) arr_data_in_d = head;

    dat_o_d = '0;
    if (rd) begin
      unique case (sel)
        2'd2:    dat_o_d = status;
        2'd3:    dat_o_d = sample_q;
        default: dat_o_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q        <= S_IDLE;
      op_q           <= OP_SAMPLE;
      tmr_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      cmderr_q       <= 1'b0;
      sample_q       <= '0;
      ack_q          <= 1'b0;
      dat_o_q        <= '0;
      arr_enable_q   <= 1'b0;
      arr_raddr_q    <= '0;
      arr_caddr_q    <= '0;
      arr_reset_q    <= 1'b0;
      arr_confclk_q  <= 1'b0;
      arr_rconfclk_q <= 1'b0;
      arr_data_in_q  <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      tmr_q          <= tmr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      cmderr_q       <= cmderr_d;
      sample_q       <= sample_d;
      ack_q          <= ack_d;
      dat_o_q        <= dat_o_d;
      arr_enable_q   <= arr_enable_d;
      arr_raddr_q    <= arr_raddr_d;
      arr_caddr_q    <= arr_caddr_d;
      arr_reset_q    <= arr_reset_d;
      arr_confclk_q  <= arr_confclk_d;
      arr_rconfclk_q <= arr_rconfclk_d;
      arr_data_in_q  <= arr_data_in_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= wb.wbs_dat_i;
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;
  assign arr_enable   = arr_enable_q;
  assign arr_raddr    = arr_raddr_q;
  assign arr_caddr    = arr_caddr_q;
  assign arr_reset    = arr_reset_q;
  assign arr_confclk  = arr_confclk_q;
  assign arr_rconfclk = arr_rconfclk_q;
  assign arr_data_in  = arr_data_in_q;

endmodule

// File: tb/tb_pnarray_conf_seq.sv
// Bench for pnarray_conf_seq: a command-level model expands each accepted command into the
// expected per-cycle pin trace, and a single process compares pins and queued bus results.
module tb_pnarray_conf_seq;
  localparam int SETUP = 2;
  localparam int PULSE = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pnarray_conf_seq_if bus();
  logic        arr_enable, arr_reset, arr_confclk, arr_rconfclk;
  logic [7:0]  arr_raddr, arr_caddr;
  logic [31:0] arr_data_in, arr_data_out;

  pnarray_conf_seq #(.SETUP(SETUP), .PULSE(PULSE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(bus),
    .arr_enable(arr_enable), .arr_raddr(arr_raddr), .arr_caddr(arr_caddr),
    .arr_reset(arr_reset), .arr_confclk(arr_confclk), .arr_rconfclk(arr_rconfclk),
    .arr_data_in(arr_data_in), .arr_data_out(arr_data_out)
  );

  typedef struct packed {
    logic        en;
    logic [2:0]  strb;   // {rconfclk, confclk, reset}
    logic        has_data;
    logic [31:0] data;
  } pin_t;

  pin_t        trace[$];
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0, m_cmderr = 1'b0;
  logic [31:0] m_sample = '0;
  logic [7:0]  exp_raddr = '0, exp_caddr = '0;
  logic        chk_en = 1'b0;

  string       ck_name[$];
  logic [31:0] ck_act[$], ck_exp[$];
  int          total = 0, bad = 0;

  logic [31:0] exp_data = '0;
  int          cc_rise = 0, cc_high = 0, rc_rise = 0, rs_rise = 0;
  logic [2:0]  prev_strb = '0, cur_strb;
  pin_t        cur_e;
  logic [51:0] act_v, exp_v;
  string       nm;
  logic [31:0] va, ve;

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
    ck_name.push_back(n);
    ck_act.push_back(a);
    ck_exp.push_back(e);
  endtask

  // Sole owner of the pass/fail counters.
  always @(negedge clk) begin
    if (!rst_n) exp_data = '0;
    while (ck_name.size() > 0) begin
      nm = ck_name.pop_front();
      va = ck_act.pop_front();
      ve = ck_exp.pop_front();
      total++;
      if (va !== ve) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, va, ve);
      end
    end
    if (chk_en) begin
      cur_e = (trace.size() > 0) ? trace.pop_front() : '0;
      if (cur_e.has_data) exp_data = cur_e.data;
      act_v = {arr_enable, arr_rconfclk, arr_confclk, arr_reset, arr_raddr, arr_caddr, arr_data_in};
      exp_v = {cur_e.en, cur_e.strb, exp_raddr, exp_caddr, exp_data};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL pins @%0t: got %h want %h", $time, act_v, exp_v);
      end
      cur_strb = {arr_rconfclk, arr_confclk, arr_reset};
      if (cur_strb[0] && !prev_strb[0]) rs_rise++;
      if (cur_strb[1] && !prev_strb[1]) cc_rise++;
      if (cur_strb[2] && !prev_strb[2]) rc_rise++;
      if (cur_strb[1]) cc_high++;
      prev_strb = cur_strb;
    end
  end

  function automatic pin_t mk(input logic en, input logic [2:0] s, input logic hd, input logic [31:0] d);
    pin_t p;
    p.en = en; p.strb = s; p.has_data = hd; p.data = d;
    return p;
  endfunction

  function automatic logic [31:0] m_status();
    return {20'h0, 4'(mq.size()), 3'b000, m_cmderr, m_ovf,
            mq.size() == 0, mq.size() == DEPTH, trace.size() > 0};
  endfunction

  task automatic xfer_start(input logic we, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] rdat);
    logic ok;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = {28'h0, a, 2'b00}; bus.wbs_dat_i = d;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!ok) begin
        @(posedge clk); #1;
        ok = bus.wbs_ack_o;
      end
    end
    rdat = bus.wbs_dat_o;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    post("ack_seen", {31'h0, ok}, 32'h1);
  endtask

  task automatic xfer_end();
    @(posedge clk); #1;
    post("ack_single", {31'h0, bus.wbs_ack_o}, 32'h0);
  endtask

  task automatic do_push(input logic [31:0] d);
    logic [31:0] r;
    xfer_start(1'b1, 2'd1, d, r);
    if (mq.size() < DEPTH) mq.push_back(d); else m_ovf = 1'b1;
    xfer_end();
  endtask

  task automatic add_word(input logic [1:0] op, input logic [31:0] w);
    logic [2:0] s;
    s = (op == 2'd1) ? 3'b001 : (op == 2'd2) ? 3'b010 : 3'b100;
    for (int i = 0; i < SETUP; i++) trace.push_back(mk(1'b1, 3'b000, op[1], w));
    if (op != 2'd0) for (int i = 0; i < PULSE; i++) trace.push_back(mk(1'b1, s, 1'b0, '0));
    for (int i = 0; i < SETUP; i++) trace.push_back(mk(1'b1, 3'b000, 1'b0, '0));
    trace.push_back('0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] ra, input logic [7:0] ca);
    logic [31:0] r;
    int n;
    xfer_start(1'b1, 2'd0, {8'h00, ca, ra, 6'h00, op}, r);
    if (trace.size() > 0) begin
      m_cmderr = 1'b1;
    end else if (!(op[1] && mq.size() == 0)) begin
      exp_raddr = ra;
      exp_caddr = ca;
      trace.push_back('0);
      n = (op == 2'd2) ? mq.size() : 1;
      for (int k = 0; k < n; k++) add_word(op, op[1] ? mq.pop_front() : 32'h0);
      if (op == 2'd0) m_sample = arr_data_out;
    end
    xfer_end();
  endtask

  task automatic rd_lit(input logic [1:0] a, input logic [31:0] e, input string n);
    logic [31:0] r;
    xfer_start(1'b0, a, 32'h0, r);
    post(n, r, e);
    xfer_end();
  endtask

  task automatic rd_model(input logic [1:0] a, input string n);
    logic [31:0] r, e;
    xfer_start(1'b0, a, 32'h0, r);
    e = (a == 2'd2) ? m_status() : (a == 2'd3) ? m_sample : 32'h0;
    post(n, r, e);
    xfer_end();
  endtask

  task automatic do_wstat();
    logic [31:0] r;
    xfer_start(1'b1, 2'd2, $urandom, r);
    m_ovf = 1'b0;
    m_cmderr = 1'b0;
    xfer_end();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (trace.size() > 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    post("idle_reached", {31'h0, trace.size() == 0}, 32'h1);
  endtask

  int          c0, h0;
  int          sel_r;
  logic [31:0] rr;

  initial begin
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    arr_data_out = '0;
    repeat (3) @(posedge clk);
    #1;
    post("rst_pins", {19'h0, arr_enable, arr_reset, arr_confclk, arr_rconfclk,
                      arr_raddr | arr_caddr}, 32'h0);
    post("rst_data_in", arr_data_in, 32'h0);
    post("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    post("rst_dat_o", bus.wbs_dat_o, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    rd_lit(2'd2, 32'h0000_0004, "rst_status");

    // 8-word CONF burst, preceded by one overflowing push
    for (int k = 1; k <= 8; k++) do_push(32'h1111_1111 * k);
    do_push(32'h9999_9999);
    rd_lit(2'd2, 32'h0000_080A, "ovf_status");
    c0 = cc_rise;
    h0 = cc_high;
    do_cmd(2'd2, 8'h02, 8'h03);
    xfer_start(1'b0, 2'd2, 32'h0, rr);
    post("busy_bit", {31'h0, rr[0]}, 32'h1);
    xfer_end();
    do_cmd(2'd1, 8'h55, 8'h66);
    wait_idle();
    post("conf_pulses", 32'(cc_rise - c0), 32'd8);
    post("conf_high", 32'(cc_high - h0), 32'd16);
    rd_lit(2'd2, 32'h0000_001C, "err_status");
    do_wstat();
    rd_lit(2'd2, 32'h0000_0004, "clr_status");

    // RCONF takes one word of two
    do_push(32'hA5A5_0001);
    do_push(32'hA5A5_0002);
    c0 = rc_rise;
    do_cmd(2'd3, 8'h01, 8'h04);
    wait_idle();
    post("rconf_pulses", 32'(rc_rise - c0), 32'd1);
    rd_lit(2'd2, 32'h0000_0100, "rconf_status");

    c0 = rs_rise;
    do_cmd(2'd1, 8'h07, 8'h09);
    wait_idle();
    post("reset_pulses", 32'(rs_rise - c0), 32'd1);
    rd_lit(2'd2, 32'h0000_0100, "reset_status");

    arr_data_out = 32'hDEAD_BEEF;
    do_cmd(2'd0, 8'h00, 8'h00);
    wait_idle();
    rd_lit(2'd3, 32'hDEAD_BEEF, "sample_lit");

    for (int it = 0; it < 60; it++) begin
      sel_r = $urandom_range(0, 9);
      if (sel_r <= 3) begin
        wait_idle();
        repeat ($urandom_range(1, 3)) do_push($urandom);
      end else if (sel_r <= 6) begin
        if (trace.size() == 0) arr_data_out = $urandom;
        do_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 8)) @(posedge clk);
        #1;
      end else if (sel_r == 7) begin
        wait_idle();
        rd_model(2'd2, "rand_status");
      end else if (sel_r == 8) begin
        wait_idle();
        rd_model(2'd3, "rand_sample");
      end else begin
        wait_idle();
        do_wstat();
      end
    end
    wait_idle();
    rd_model(2'd2, "final_status");

    // Abort a CONF while its strobe is high
    do_wstat();
    for (int k = 0; k < 3; k++) do_push($urandom);
    do_cmd(2'd2, 8'h0A, 8'h0B);
    c0 = 0;
    while (!arr_confclk && c0 < 40) begin
      @(posedge clk); #1;
      c0++;
    end
    post("abort_strobe_seen", {31'h0, arr_confclk}, 32'h1);
    rst_n = 1'b0;
    chk_en = 1'b0;
    trace.delete();
    mq.delete();
    m_ovf = 1'b0; m_cmderr = 1'b0; m_sample = '0;
    exp_raddr = '0; exp_caddr = '0;
    @(posedge clk); #1;
    post("abort_pins", {19'h0, arr_enable, arr_reset, arr_confclk, arr_rconfclk,
                        arr_raddr | arr_caddr}, 32'h0);
    post("abort_data_in", arr_data_in, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    rd_lit(2'd2, 32'h0000_0004, "abort_status");
    rd_lit(2'd3, 32'h0000_0000, "abort_sample");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
